// File: rtl/i2c_master_arbiter_if.sv
// Bundle of requester-side and I2C-master-side signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (requesters plus the I2C master engine).
interface i2c_master_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int ADDR_LEN = 7,
  parameter int DATA_LEN = 8
);
  // Requester side
  logic [N_REQ-1:0]            req;
  logic [N_REQ*ADDR_LEN-1:0]   req_addr;
  logic [N_REQ-1:0]            req_rw;
  logic [N_REQ*2*DATA_LEN-1:0] req_wdata;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            done;
  logic                        err;
  logic [2*DATA_LEN-1:0]       rdata;

  // I2C master side
  logic                        m_start;
  logic [ADDR_LEN-1:0]         m_addr;
  logic                        m_rw;
  logic [DATA_LEN-1:0]         m_data_1;
  logic [DATA_LEN-1:0]         m_data_2;
  logic                        m_free;
  logic                        m_ack_fail;
  logic [2*DATA_LEN-1:0]       m_rdata;

  modport slave (
    input  req, req_addr, req_rw, req_wdata, m_free, m_ack_fail, m_rdata,
    output gnt, done, err, rdata, m_start, m_addr, m_rw, m_data_1, m_data_2
  );

  modport master (
    output req, req_addr, req_rw, req_wdata, m_free, m_ack_fail, m_rdata,
    input  gnt, done, err, rdata, m_start, m_addr, m_rw, m_data_1, m_data_2
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master between N_REQ requesters.
// Each granted transaction carries one address, an R/W bit and two data
// bytes; the arbiter launches the master, tracks busy/free with timeouts,
// collects NACKs and returns a one-cycle done pulse with an error flag.
module i2c_master_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_LEN = 7,
  parameter int DATA_LEN = 8,
  parameter int BUSY_TO  = 15,
  parameter int XFER_TO  = 4095
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i2c_master_arbiter_if.slave   bus
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_TOP = (BUSY_TO > XFER_TO) ? BUSY_TO : XFER_TO;
  localparam int CNT_W   = ($clog2(CNT_TOP + 1) > 0) ? $clog2(CNT_TOP + 1) : 1;

  localparam logic [CNT_W-1:0] BUSY_LIM = CNT_W'(BUSY_TO);
  localparam logic [CNT_W-1:0] XFER_LIM = CNT_W'(XFER_TO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    COMPLETE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [CNT_W-1:0] cnt;
  logic             nack;
  logic             tmo;

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] pick;
  logic             pick_hit;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_wait;
  logic             nack_now;
  logic             to_hit;
  logic             finish;
  logic             err_now;

  // Round-robin pick: rotate requests so ptr sits at bit 0, take the first set bit.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    rot      = N_REQ'({bus.req, bus.req} >> ptr);
    pick     = ptr;
    pick_hit = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_hit && rot[k]) begin
        pick_hit = 1'b1;
        pick     = IDX_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  // Saturating counter increment, NACK accumulation and completion conditions.
  always_comb begin
    cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    in_wait  = (state == WAIT_BUSY) || (state == WAIT_DONE);
    nack_now = nack | (in_wait & bus.m_ack_fail);
    to_hit   = ((state == WAIT_BUSY) &&  bus.m_free && (cnt >= BUSY_LIM)) ||
               ((state == WAIT_DONE) && !bus.m_free && (cnt >= XFER_LIM));
    finish   = to_hit || ((state == WAIT_DONE) && bus.m_free);
    err_now  = nack_now | tmo | to_hit;
  end

  // Transaction FSM with registered grant, master-side and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      win          <= '0;
      cnt          <= '0;
      nack         <= 1'b0;
      tmo          <= 1'b0;
      bus.gnt      <= '0;
      bus.done     <= '0;
      bus.err      <= 1'b0;
      bus.rdata    <= '0;
      bus.m_start  <= 1'b0;
      bus.m_addr   <= '0;
      bus.m_rw     <= 1'b0;
      bus.m_data_1 <= '0;
      bus.m_data_2 <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values; the completion block below relies
      // on the last non-blocking write in this block taking effect.
      case (state)
        IDLE: begin
          if (pick_hit && bus.m_free) begin
            win          <= pick;
            bus.gnt      <= N_REQ'(1) << pick;
            bus.m_addr   <= bus.req_addr[pick*ADDR_LEN +: ADDR_LEN];
            bus.m_rw     <= bus.req_rw[pick];
            bus.m_data_1 <= bus.req_wdata[pick*2*DATA_LEN + DATA_LEN +: DATA_LEN];
            bus.m_data_2 <= bus.req_wdata[pick*2*DATA_LEN +: DATA_LEN];
            bus.m_start  <= 1'b1;
            nack         <= 1'b0;
            tmo          <= 1'b0;
            cnt          <= '0;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          bus.m_start <= 1'b0;
          cnt         <= '0;
          state       <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          nack <= nack_now;
          if (!bus.m_free) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_DONE: begin
          nack <= nack_now;
          cnt  <= cnt_inc;
        end
        COMPLETE: begin
          bus.gnt  <= '0;
          bus.done <= '0;
          bus.err  <= 1'b0;
          ptr      <= (win == LAST_IDX) ? '0 : win + IDX_W'(1);
          cnt      <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Entry into COMPLETE from either wait state: completion outputs are
      // registered so they are valid for exactly the COMPLETE cycle.
      if (finish) begin
        state    <= COMPLETE;
        cnt      <= '0;
        tmo      <= tmo | to_hit;
        bus.done <= bus.gnt;
        bus.err  <= err_now;
        if (bus.m_rw && !err_now) begin
          bus.rdata <= bus.m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed self-checking bench for i2c_master_arbiter: reset values,
// round-robin order, write/read transactions, NACK, both timeouts,
// mid-transaction request changes and reset abandoning a transaction.
module tb_i2c_master_arbiter;

  localparam int N_REQ    = 4;
  localparam int ADDR_LEN = 7;
  localparam int DATA_LEN = 8;
  localparam int BUSY_TO  = 15;
  localparam int XFER_TO  = 4095;

  logic clk = 1'b0;
  logic rst_n;

  int checks    = 0;
  int failures  = 0;
  int start_cnt = 0;
  int done_cnt  = 0;

  always #5 clk = ~clk;

  i2c_master_arbiter_if #(.N_REQ(N_REQ), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) bus ();

  i2c_master_arbiter #(
    .N_REQ   (N_REQ),
    .ADDR_LEN(ADDR_LEN),
    .DATA_LEN(DATA_LEN),
    .BUSY_TO (BUSY_TO),
    .XFER_TO (XFER_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Count m_start and done cycles, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.m_start) start_cnt++;
    if (bus.done != '0) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [ADDR_LEN-1:0] a, input logic rw,
                          input logic [2*DATA_LEN-1:0] wd);
    bus.req_addr[i*ADDR_LEN +: ADDR_LEN]       = a;
    bus.req_rw[i]                              = rw;
    bus.req_wdata[i*2*DATA_LEN +: 2*DATA_LEN]  = wd;
  endtask

  // Wait (bounded) for m_start; returns the number of falling edges waited.
  task automatic wait_start(input string tag, input int budget, output int waited);
    logic found;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < budget) begin
      @(negedge clk);
      waited++;
      if (bus.m_start) found = 1'b1;
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  // Wait (bounded) for a done pulse; returns the number of falling edges waited.
  task automatic wait_done(input string tag, input int budget, output int waited);
    logic found;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < budget) begin
      @(negedge clk);
      waited++;
      if (bus.done != '0) found = 1'b1;
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  // Simple master model: called at the LAUNCH cycle, goes busy for n cycles.
  task automatic do_master(input int n);
    @(negedge clk);
    bus.m_free = 1'b0;
    repeat (n) @(negedge clk);
    bus.m_free = 1'b1;
  endtask

  initial begin
    int w;
    int lat;
    int s0;
    int d0;

    rst_n          = 1'b0;
    bus.req        = '0;
    bus.req_addr   = '0;
    bus.req_rw     = '0;
    bus.req_wdata  = '0;
    bus.m_free     = 1'b1;
    bus.m_ack_fail = 1'b0;
    bus.m_rdata    = '0;
    for (int i = 0; i < N_REQ; i++) set_slot(i, ADDR_LEN'(7'h10 + i), 1'b0, 16'h1100 * i);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_gnt",     bus.gnt,      0);
    check("rst_done",    bus.done,     0);
    check("rst_err",     bus.err,      0);
    check("rst_m_start", bus.m_start,  0);
    check("rst_rdata",   bus.rdata,    0);
    check("rst_m_addr",  bus.m_addr,   0);
    check("rst_m_data1", bus.m_data_1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin with all four requesting: 0,1,2,3 then 0
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start("rr_start", 10, w);
      if (k == 0) check("rr_first_latency", w, 1);
      else        check("rr_done_to_start_gap", w, 2);
      check("rr_gnt",  bus.gnt,    1 << (k % 4));
      check("rr_addr", bus.m_addr, 32'h10 + (k % 4));
      do_master(3);
      wait_done("rr_done", 50, lat);
      check("rr_done", bus.done, 1 << (k % 4));
      check("rr_err",  bus.err,  0);
    end
    bus.req = '0;

    // Single write from requester 0 (ptr is now 1)
    set_slot(0, 7'h50, 1'b0, 16'hA55A);
    bus.req = 4'b0001;
    s0 = start_cnt;
    wait_start("wr_start", 10, w);
    check("wr_gnt",    bus.gnt,      4'b0001);
    check("wr_m_addr", bus.m_addr,   7'h50);
    check("wr_m_rw",   bus.m_rw,     0);
    check("wr_data1",  bus.m_data_1, 8'hA5);
    check("wr_data2",  bus.m_data_2, 8'h5A);
    @(negedge clk);
    check("wr_start_one_cycle", bus.m_start, 0);
    bus.m_free = 1'b0;
    repeat (100) @(negedge clk);
    check("wr_gnt_held", bus.gnt, 4'b0001);
    bus.m_free = 1'b1;
    wait_done("wr_done", 10, lat);
    check("wr_done_latency", lat, 1);
    check("wr_done",         bus.done, 4'b0001);
    check("wr_err",          bus.err,  0);
    check("wr_data1_stable", bus.m_data_1, 8'hA5);
    check("wr_start_count",  start_cnt - s0, 1);
    bus.req = '0;
    @(negedge clk);
    check("wr_done_pulse_one", bus.done, 0);
    check("wr_gnt_released",   bus.gnt,  0);

    // Read from requester 2
    set_slot(2, 7'h2C, 1'b1, 16'h0000);
    bus.req     = 4'b0100;
    bus.m_rdata = 16'h1234;
    wait_start("rd_start", 10, w);
    check("rd_gnt",  bus.gnt,    4'b0100);
    check("rd_m_rw", bus.m_rw,   1);
    check("rd_addr", bus.m_addr, 7'h2C);
    do_master(5);
    wait_done("rd_done", 10, lat);
    check("rd_done",  bus.done,  4'b0100);
    check("rd_err",   bus.err,   0);
    check("rd_rdata", bus.rdata, 16'h1234);
    bus.req     = '0;
    bus.m_rdata = 16'h0000;
    @(negedge clk);
    check("rd_rdata_held", bus.rdata, 16'h1234);

    // NACK on a read from requester 3: err set, rdata untouched
    set_slot(3, 7'h3A, 1'b1, 16'h0000);
    bus.req     = 4'b1000;
    bus.m_rdata = 16'hBEEF;
    wait_start("nk_start", 10, w);
    check("nk_gnt", bus.gnt, 4'b1000);
    @(negedge clk);
    bus.m_free = 1'b0;
    @(negedge clk);
    bus.m_ack_fail = 1'b1;
    @(negedge clk);
    bus.m_ack_fail = 1'b0;
    repeat (4) @(negedge clk);
    bus.m_free = 1'b1;
    wait_done("nk_done", 10, lat);
    check("nk_done",        bus.done,   4'b1000);
    check("nk_err",         bus.err,    1);
    check("nk_rdata_kept",  bus.rdata,  16'h1234);
    check("nk_addr_stable", bus.m_addr, 7'h3A);
    bus.req = '0;

    // Requester 1 drops req mid-transaction while requester 0 arrives
    set_slot(1, 7'h21, 1'b0, 16'h1357);
    bus.req = 4'b0010;
    wait_start("dr_start", 10, w);
    check("dr_gnt", bus.gnt, 4'b0010);
    @(negedge clk);
    bus.m_free = 1'b0;
    @(negedge clk);
    bus.req = 4'b0001;
    repeat (4) @(negedge clk);
    check("dr_gnt_kept", bus.gnt, 4'b0010);
    bus.m_free = 1'b1;
    wait_done("dr_done", 10, lat);
    check("dr_done", bus.done, 4'b0010);
    check("dr_err_cleared", bus.err, 0);
    wait_start("dr_next_start", 10, w);
    check("dr_next_gap",  w,          2);
    check("dr_next_gnt",  bus.gnt,    4'b0001);
    check("dr_next_addr", bus.m_addr, 7'h50);
    do_master(2);
    wait_done("dr_next_done", 10, lat);
    check("dr_next_done", bus.done, 4'b0001);
    bus.req = '0;

    // Master not free in IDLE: no grant until m_free rises
    set_slot(2, 7'h2C, 1'b1, 16'h0000);
    bus.m_rdata = 16'h5AA5;
    bus.m_free  = 1'b0;
    bus.req     = 4'b0100;
    s0 = start_cnt;
    repeat (6) @(negedge clk);
    check("nf_no_gnt",   bus.gnt, 0);
    check("nf_no_start", start_cnt - s0, 0);
    bus.m_free = 1'b1;
    wait_start("nf_start", 10, w);
    check("nf_latency", w, 1);
    check("nf_gnt", bus.gnt, 4'b0100);
    do_master(2);
    wait_done("nf_done", 10, lat);
    check("nf_rdata", bus.rdata, 16'h5AA5);
    bus.req = '0;

    // Busy timeout: master never leaves free after m_start (requester 3)
    set_slot(3, 7'h3B, 1'b0, 16'h2468);
    bus.req = 4'b1000;
    wait_start("bt_start", 10, w);
    check("bt_gnt", bus.gnt, 4'b1000);
    wait_done("bt_done", 40, lat);
    check("bt_latency", lat, BUSY_TO + 2);
    check("bt_done",    bus.done, 4'b1000);
    check("bt_err",     bus.err,  1);
    bus.req = '0;

    // Transfer timeout: master stays busy forever (requester 0)
    bus.req = 4'b0001;
    wait_start("xt_start", 10, w);
    check("xt_gnt", bus.gnt, 4'b0001);
    bus.m_free = 1'b0;
    wait_done("xt_done", 5000, lat);
    check("xt_latency", lat, XFER_TO + 3);
    check("xt_done",    bus.done, 4'b0001);
    check("xt_err",     bus.err,  1);
    bus.req    = '0;
    bus.m_free = 1'b1;

    // Reset in WAIT_DONE: abandon, no done, restart from requester 0
    set_slot(2, 7'h2D, 1'b0, 16'h9999);
    bus.req = 4'b0100;
    wait_start("rs_start", 10, w);
    check("rs_gnt", bus.gnt, 4'b0100);
    @(negedge clk);
    bus.m_free = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("rs_gnt_async",   bus.gnt,    0);
    check("rs_rdata_async", bus.rdata,  0);
    check("rs_addr_async",  bus.m_addr, 0);
    @(negedge clk);
    bus.req    = 4'b1001;
    bus.m_free = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check("rs_no_done", done_cnt - d0, 0);
    wait_start("rs_restart", 10, w);
    check("rs_restart_latency", w, 1);
    check("rs_restart_gnt",  bus.gnt,    4'b0001);
    check("rs_restart_addr", bus.m_addr, 7'h50);
    do_master(2);
    wait_done("rs_done", 10, lat);
    check("rs_done", bus.done, 4'b0001);
    bus.req = '0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
